// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer
//   Reads the 16-bit instruction memory through two read ports.
//   Port 1 is addressed with pc and port 2 with pc+1.
//   It assembles 16/32-bit instructions and hands them to decode over valid/ready.
//   Optional breakpoint/halt support is compiled in with `define FETCH_BREAKPOINT_EN.
module instruction_fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 20,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_enable,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] instruction_rd1,
  output logic [ADDR_WIDTH-1:0] instruction_rd2,
  input  logic [15:0]           instruction_rd1_out,
  input  logic [15:0]           instruction_rd2_out,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  output logic [31:0]           fetch_instruction,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  fetch_is_long,
`ifdef FETCH_BREAKPOINT_EN
  input  logic                  bp_enable,
  input  logic [ADDR_WIDTH-1:0] bp_addr,
  input  logic                  resume,
`endif
  output logic                  fetch_halted
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic                    valid_q;
  logic [31:0]             instr_q;
  logic [ADDR_WIDTH-1:0]   fpc_q;
  logic                    long_q;

  logic                    slot_free_d;
  logic                    is_long_d;
  logic [ADDR_WIDTH-1:0]   pc_next_d;
  logic [31:0]             instr_d;
  logic                    bp_hit_d;

  // Both read addresses follow pc directly; pc+1 wraps naturally at the top of memory
  assign instruction_rd1 = pc_q;
  assign instruction_rd2 = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Fetch decode: bit 15 of the first halfword marks a 32-bit instruction
  assign slot_free_d = !valid_q || fetch_ready;
  assign is_long_d   = instruction_rd1_out[15];
  assign pc_next_d   = pc_q + {{(ADDR_WIDTH-2){1'b0}}, is_long_d, !is_long_d};
  assign instr_d     = is_long_d ? {instruction_rd2_out, instruction_rd1_out}
                                 : {16'h0000, instruction_rd1_out};

`ifdef FETCH_BREAKPOINT_EN
  logic halted_q;
  logic bp_skip_q;  // set by resume so the breakpoint address is fetched once

  assign bp_hit_d     = bp_enable && (pc_q == bp_addr) && !bp_skip_q;
  assign fetch_halted = halted_q;
`else
  assign bp_hit_d     = 1'b0;
  assign fetch_halted = 1'b0;
`endif

  assign fetch_valid       = valid_q;
  assign fetch_instruction = instr_q;
  assign fetch_pc          = fpc_q;
  assign fetch_is_long     = long_q;

  // Sequencer FSM with its registered outputs; a branch overrides everything else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      instr_q   <= 32'h0;
      fpc_q     <= '0;
      long_q    <= 1'b0;
`ifdef FETCH_BREAKPOINT_EN
      halted_q  <= 1'b0;
      bp_skip_q <= 1'b0;
`endif
    end else if (branch_valid) begin
      // Redirect: discard whatever is held or in flight
      pc_q    <= branch_target;
      valid_q <= 1'b0;
      if (state_q == ST_HALTED) begin
        state_q <= ST_RUN;
      end
`ifdef FETCH_BREAKPOINT_EN
      halted_q  <= 1'b0;
      bp_skip_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_enable) begin
            state_q <= ST_RUN;
          end
          if (slot_free_d) begin
            valid_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!fetch_enable) begin
            state_q <= ST_IDLE;
          end
          if (slot_free_d) begin
            if (fetch_enable && bp_hit_d) begin
              state_q <= ST_HALTED;
              valid_q <= 1'b0;
`ifdef FETCH_BREAKPOINT_EN
              halted_q <= 1'b1;
`endif
            end else if (fetch_enable) begin
              valid_q <= 1'b1;
              instr_q <= instr_d;
              fpc_q   <= pc_q;
              long_q  <= is_long_d;
              pc_q    <= pc_next_d;
`ifdef FETCH_BREAKPOINT_EN
              bp_skip_q <= 1'b0;
`endif
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
        ST_HALTED: begin
          if (slot_free_d) begin
            valid_q <= 1'b0;
          end
`ifdef FETCH_BREAKPOINT_EN
          if (resume) begin
            state_q   <= ST_RUN;
            halted_q  <= 1'b0;
            bp_skip_q <= 1'b1;
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer with a small behavioural memory.
module tb_instruction_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic        branch_valid;
  logic [19:0] branch_target;
  logic [19:0] instruction_rd1;
  logic [19:0] instruction_rd2;
  logic [15:0] instruction_rd1_out;
  logic [15:0] instruction_rd2_out;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instruction;
  logic [19:0] fetch_pc;
  logic        fetch_is_long;
  logic        fetch_halted;
`ifdef FETCH_BREAKPOINT_EN
  logic        bp_enable;
  logic [19:0] bp_addr;
  logic        resume;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  // Memory contents: a few fixed words, everything else a short instruction equal to addr[11:0]
  function automatic logic [15:0] mem_word(input logic [19:0] a);
    case (a)
      20'h00000: return 16'h1234;
      20'h00004: return 16'h8001;
      20'h00005: return 16'hBEEF;
      20'hFFFFF: return 16'h9ABC;
      default:   return {4'h0, a[11:0]};
    endcase
  endfunction

  assign instruction_rd1_out = mem_word(instruction_rd1);
  assign instruction_rd2_out = mem_word(instruction_rd2);

  instruction_fetch_sequencer dut (
    .clock               (clock),
    .reset               (reset),
    .fetch_enable        (fetch_enable),
    .branch_valid        (branch_valid),
    .branch_target       (branch_target),
    .instruction_rd1     (instruction_rd1),
    .instruction_rd2     (instruction_rd2),
    .instruction_rd1_out (instruction_rd1_out),
    .instruction_rd2_out (instruction_rd2_out),
    .fetch_valid         (fetch_valid),
    .fetch_ready         (fetch_ready),
    .fetch_instruction   (fetch_instruction),
    .fetch_pc            (fetch_pc),
    .fetch_is_long       (fetch_is_long),
`ifdef FETCH_BREAKPOINT_EN
    .bp_enable           (bp_enable),
    .bp_addr             (bp_addr),
    .resume              (resume),
`endif
    .fetch_halted        (fetch_halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Checks the full output register set in one go
  task automatic check_out(input string tag, input logic v, input logic [19:0] pc,
                           input logic [31:0] ins, input logic lg);
    check({tag, ".valid"}, {31'h0, fetch_valid}, {31'h0, v});
    check({tag, ".pc"},    {12'h0, fetch_pc},    {12'h0, pc});
    check({tag, ".instr"}, fetch_instruction,    ins);
    check({tag, ".long"},  {31'h0, fetch_is_long}, {31'h0, lg});
  endtask

  initial begin
    reset         = 1'b1;
    fetch_enable  = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 20'h0;
    fetch_ready   = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
    bp_enable     = 1'b0;
    bp_addr       = 20'h0;
    resume        = 1'b0;
`endif
    tick();
    tick();
    // Reset values
    check_out("reset", 1'b0, 20'h0, 32'h0, 1'b0);
    check("reset.halted", {31'h0, fetch_halted}, 32'h0);
    check("reset.rd1", {12'h0, instruction_rd1}, 32'h0);
    check("reset.rd2", {12'h0, instruction_rd2}, 32'h1);

    reset        = 1'b0;
    fetch_enable = 1'b1;
    fetch_ready  = 1'b1;
    tick();  // IDLE -> RUN, nothing fetched yet
    check("start.valid", {31'h0, fetch_valid}, 32'h0);
    tick();  // pc 0
    check_out("seq0", 1'b1, 20'h0, 32'h00001234, 1'b0);
    check("seq0.rd1", {12'h0, instruction_rd1}, 32'h1);
    tick();
    check_out("seq1", 1'b1, 20'h1, 32'h00000001, 1'b0);
    tick();
    check_out("seq2", 1'b1, 20'h2, 32'h00000002, 1'b0);
    tick();
    check_out("seq3", 1'b1, 20'h3, 32'h00000003, 1'b0);
    tick();  // long instruction at 4
    check_out("long4", 1'b1, 20'h4, 32'hBEEF8001, 1'b1);
    check("long4.rd1", {12'h0, instruction_rd1}, 32'h6);
    tick();
    check_out("seq6", 1'b1, 20'h6, 32'h00000006, 1'b0);

    // Stall for five cycles: everything holds
    fetch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("stall", 1'b1, 20'h6, 32'h00000006, 1'b0);
      check("stall.rd1", {12'h0, instruction_rd1}, 32'h7);
      check("stall.rd2", {12'h0, instruction_rd2}, 32'h8);
    end
    fetch_ready = 1'b1;
    tick();
    check_out("unstall", 1'b1, 20'h7, 32'h00000007, 1'b0);

    // Branch while stalled
    fetch_ready = 1'b0;
    tick();
    check_out("stall7", 1'b1, 20'h7, 32'h00000007, 1'b0);
    branch_valid  = 1'b1;
    branch_target = 20'h00100;
    tick();
    branch_valid = 1'b0;
    check("br.valid", {31'h0, fetch_valid}, 32'h0);
    check("br.rd1", {12'h0, instruction_rd1}, 32'h100);
    tick();
    check_out("br.first", 1'b1, 20'h00100, 32'h00000100, 1'b0);

    // Long instruction straddling the top of memory
    fetch_ready   = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 20'hFFFFF;
    tick();
    branch_valid = 1'b0;
    check("wrap.valid", {31'h0, fetch_valid}, 32'h0);
    check("wrap.rd1", {12'h0, instruction_rd1}, 32'hFFFFF);
    check("wrap.rd2", {12'h0, instruction_rd2}, 32'h0);
    tick();
    check_out("wrap", 1'b1, 20'hFFFFF, 32'h12349ABC, 1'b1);
    check("wrap.nextpc", {12'h0, instruction_rd1}, 32'h1);

    // Enable dropped mid-stall: held instruction stays until accepted
    fetch_ready  = 1'b0;
    fetch_enable = 1'b0;
    tick();
    check_out("drain.hold", 1'b1, 20'hFFFFF, 32'h12349ABC, 1'b1);
    fetch_ready = 1'b1;
    tick();
    check("drain.valid", {31'h0, fetch_valid}, 32'h0);
    check("drain.rd1", {12'h0, instruction_rd1}, 32'h1);
    tick();
    check("idle.valid", {31'h0, fetch_valid}, 32'h0);

    // Branch in IDLE only moves pc
    branch_valid  = 1'b1;
    branch_target = 20'h00003;
    tick();
    branch_valid = 1'b0;
    check("idlebr.rd1", {12'h0, instruction_rd1}, 32'h3);
    check("idlebr.valid", {31'h0, fetch_valid}, 32'h0);
    fetch_enable = 1'b1;
    tick();
    check("rerun.valid", {31'h0, fetch_valid}, 32'h0);
    tick();
    check_out("rerun", 1'b1, 20'h3, 32'h00000003, 1'b0);

    // Asynchronous reset mid-operation
    #2;
    reset = 1'b1;
    #1;
    check_out("areset", 1'b0, 20'h0, 32'h0, 1'b0);
    check("areset.rd1", {12'h0, instruction_rd1}, 32'h0);
    tick();
    reset = 1'b0;

`ifdef FETCH_BREAKPOINT_EN
    // Breakpoint at 3 from pc 0
    bp_enable = 1'b1;
    bp_addr   = 20'h3;
    tick();  // IDLE -> RUN
    tick();
    check_out("bp0", 1'b1, 20'h0, 32'h00001234, 1'b0);
    tick();
    check_out("bp1", 1'b1, 20'h1, 32'h00000001, 1'b0);
    tick();
    check_out("bp2", 1'b1, 20'h2, 32'h00000002, 1'b0);
    tick();
    check("bp.halted", {31'h0, fetch_halted}, 32'h1);
    check("bp.valid", {31'h0, fetch_valid}, 32'h0);
    check("bp.rd1", {12'h0, instruction_rd1}, 32'h3);
    tick();
    check("bp.stay", {31'h0, fetch_halted}, 32'h1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume.halted", {31'h0, fetch_halted}, 32'h0);
    tick();
    check_out("resume3", 1'b1, 20'h3, 32'h00000003, 1'b0);
    check("resume3.halted", {31'h0, fetch_halted}, 32'h0);
    tick();
    check_out("resume4", 1'b1, 20'h4, 32'hBEEF8001, 1'b1);
`else
    tick();
    check("halted.tied", {31'h0, fetch_halted}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
